// File: rtl/frac_clken_pkg.sv
// Shared types and helpers for the fractional clock-enable generator.
// Holds the lock FSM state encoding and the reconfiguration request check.
package frac_clken_pkg;

  localparam int ACC_W_DEFAULT = 24;

  typedef enum logic [1:0] {
    SETTLE = 2'd0,
    LOCKED = 2'd1,
    APPLY  = 2'd2
  } lock_state_t;

  // Operands are zero-extended by the caller so one function serves every width.
  function automatic logic cfg_is_valid(input logic [63:0] num,
                                        input logic [63:0] den,
                                        input logic [63:0] chan,
                                        input logic [63:0] nchan);
    return (den != 64'd0) && (num <= den) && (chan < nchan);
  endfunction

endpackage

// File: rtl/frac_clken_chan.sv
// One phase-accumulator channel: registered ce, one cycle from accumulate to strobe.
// No backpressure; i_load reloads the ratio, clears phase and suppresses ce for that cycle.
module frac_clken_chan #(
  parameter int               ACC_W    = 24,
  parameter logic [ACC_W-1:0] INIT_NUM = ACC_W'(1),
  parameter logic [ACC_W-1:0] INIT_DEN = ACC_W'(4)
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [ACC_W-1:0] i_num,
  input  logic [ACC_W-1:0] i_den,
  output logic             o_ce
);

  // Out-of-range reset ratios are clamped so the accumulator can never run away.
  localparam logic [ACC_W-1:0] DEN_RST = (INIT_DEN == '0) ? ACC_W'(1) : INIT_DEN;
  localparam logic [ACC_W-1:0] NUM_RST = (INIT_NUM > DEN_RST) ? DEN_RST : INIT_NUM;

  logic [ACC_W-1:0] r_acc;
  logic [ACC_W-1:0] r_num;
  logic [ACC_W-1:0] r_den;
  logic             r_ce;

  logic [ACC_W:0]   w_sum;
  logic [ACC_W:0]   w_diff;
  logic             w_wrap;

  assign w_sum  = {1'b0, r_acc} + {1'b0, r_num};
  assign w_wrap = (w_sum >= {1'b0, r_den});
  assign w_diff = w_sum - {1'b0, r_den};

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_acc <= '0;
      r_num <= NUM_RST;
      r_den <= DEN_RST;
      r_ce  <= 1'b0;
    end else if (i_load) begin
      r_acc <= '0;
      r_num <= i_num;
      r_den <= i_den;
      r_ce  <= 1'b0;
    end else begin
      r_acc <= w_wrap ? ACC_W'(w_diff) : ACC_W'(w_sum);
      r_ce  <= w_wrap;
    end
  end

  assign o_ce = r_ce;

endmodule

// File: rtl/frac_clken_gen.sv
// CHANNELS fractional enable strobes from refclk plus a global lock/reconfig FSM.
// cfg_ready only in LOCKED; request applied one cycle after handshake, no queueing.
module frac_clken_gen
  import frac_clken_pkg::*;
#(
  parameter int                          CHANNELS    = 2,
  parameter int                          ACC_W       = ACC_W_DEFAULT,
  parameter int                          LOCK_CYCLES = 16,
  parameter logic [CHANNELS*ACC_W-1:0]   INIT_NUM    = {CHANNELS{ACC_W'(1)}},
  parameter logic [CHANNELS*ACC_W-1:0]   INIT_DEN    = {CHANNELS{ACC_W'(4)}}
) (
  input  logic                                             refclk,
  input  logic                                             rst,
  input  logic                                             cfg_valid,
  output logic                                             cfg_ready,
  input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_chan,
  input  logic [ACC_W-1:0]                                 cfg_num,
  input  logic [ACC_W-1:0]                                 cfg_den,
  output logic                                             cfg_err,
  output logic [CHANNELS-1:0]                              ce_out,
  output logic                                             locked
);

  localparam int               CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int               CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_CYCLES - 1);

  lock_state_t      r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_err;
  logic [CH_W-1:0]  r_apply_chan;
  logic [ACC_W-1:0] r_apply_num;
  logic [ACC_W-1:0] r_apply_den;

  lock_state_t      w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_err_nxt;
  logic             w_capture;
  logic             w_req_ok;
  logic [CHANNELS-1:0] w_load;

  assign w_req_ok = cfg_is_valid(64'(cfg_num), 64'(cfg_den), 64'(cfg_chan), 64'(CHANNELS));

  always_ff @(posedge refclk) begin
    if (rst) begin
      r_state      <= SETTLE;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_apply_chan <= '0;
      r_apply_num  <= '0;
      r_apply_den  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      if (w_capture) begin
        r_apply_chan <= cfg_chan;
        r_apply_num  <= cfg_num;
        r_apply_den  <= cfg_den;
      end
    end
  end

  // Rejected requests still consume the handshake; they only raise cfg_err.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = 1'b0;
    w_capture   = 1'b0;
    case (r_state)
      SETTLE: begin
        if (r_cnt == CNT_LAST) begin
          w_state_nxt = LOCKED;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      LOCKED: begin
        if (cfg_valid) begin
          if (w_req_ok) begin
            w_state_nxt = APPLY;
            w_capture   = 1'b1;
          end else begin
            w_err_nxt = 1'b1;
          end
        end
      end
      APPLY: begin
        w_state_nxt = SETTLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = SETTLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
    assign w_load[g] = (r_state == APPLY) && (r_apply_chan == CH_W'(g));

    frac_clken_chan #(
      .ACC_W    (ACC_W),
      .INIT_NUM (INIT_NUM[g*ACC_W +: ACC_W]),
      .INIT_DEN (INIT_DEN[g*ACC_W +: ACC_W])
    ) u_chan (
      .refclk (refclk),
      .rst    (rst),
      .i_load (w_load[g]),
      .i_num  (r_apply_num),
      .i_den  (r_apply_den),
      .o_ce   (ce_out[g])
    );
  end

  assign cfg_ready = (r_state == LOCKED);
  assign locked    = (r_state == LOCKED);
  assign cfg_err   = r_err;

endmodule

// File: tb/tb_frac_clken_gen.sv
// Directed bench for frac_clken_gen with a floor-arithmetic reference model.
module tb_frac_clken_gen;

  localparam int CH = 2;
  localparam int AW = 24;
  localparam int LC = 16;
  localparam logic [CH*AW-1:0] I_NUM = {24'd5, 24'd1};
  localparam logic [CH*AW-1:0] I_DEN = {24'd5, 24'd4};

  logic          refclk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_valid = 1'b0;
  logic          cfg_chan = 1'b0;
  logic [AW-1:0] cfg_num = '0;
  logic [AW-1:0] cfg_den = '0;
  logic          cfg_ready;
  logic          cfg_err;
  logic          locked;
  logic [CH-1:0] ce_out;

  int checks = 0;
  int errors = 0;

  always #5 refclk = ~refclk;

  frac_clken_gen #(
    .CHANNELS    (CH),
    .ACC_W       (AW),
    .LOCK_CYCLES (LC),
    .INIT_NUM    (I_NUM),
    .INIT_DEN    (I_DEN)
  ) dut (
    .refclk    (refclk),
    .rst       (rst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_num   (cfg_num),
    .cfg_den   (cfg_den),
    .cfg_err   (cfg_err),
    .ce_out    (ce_out),
    .locked    (locked)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference model: channel i strobes after edge k iff floor(k*N/D) grew.
  longint        m_num [CH];
  longint        m_den [CH];
  longint        m_k   [CH];
  logic [CH-1:0] m_ce;
  int            m_since;
  bit            m_apply;
  int            m_ach;
  longint        m_anum;
  longint        m_aden;
  bit            m_err;
  bit            m_live = 1'b0;
  bit            m_lk;

  function automatic logic strobe(input longint k, input longint n, input longint d);
    return ((k * n) / d) > (((k - 1) * n) / d);
  endfunction

  always @(posedge refclk) begin
    if (rst) begin
      for (int c = 0; c < CH; c++) begin
        m_num[c] = longint'(I_NUM[c*AW +: AW]);
        m_den[c] = longint'(I_DEN[c*AW +: AW]);
        m_k[c]   = 0;
      end
      m_ce    = '0;
      m_since = 0;
      m_apply = 1'b0;
      m_err   = 1'b0;
      m_live  = 1'b1;
    end else begin
      m_lk  = !m_apply && (m_since >= LC);
      m_err = 1'b0;
      for (int c = 0; c < CH; c++) begin
        if (m_apply && c == m_ach) begin
          m_num[c] = m_anum;
          m_den[c] = m_aden;
          m_k[c]   = 0;
          m_ce[c]  = 1'b0;
        end else begin
          m_k[c]  = m_k[c] + 1;
          m_ce[c] = strobe(m_k[c], m_num[c], m_den[c]);
        end
      end
      if (m_apply) begin
        m_apply = 1'b0;
        m_since = 0;
      end else if (m_lk) begin
        if (cfg_valid) begin
          if (cfg_den != 0 && cfg_num <= cfg_den) begin
            m_apply = 1'b1;
            m_ach   = int'(cfg_chan);
            m_anum  = longint'(cfg_num);
            m_aden  = longint'(cfg_den);
          end else begin
            m_err = 1'b1;
          end
        end
      end else begin
        m_since = m_since + 1;
      end
    end
  end

  logic [CH+2:0] cmp_exp;
  logic [CH+2:0] cmp_act;
  logic          cmp_lk;

  always @(negedge refclk) begin
    if (m_live) begin
      cmp_lk  = !m_apply && (m_since >= LC);
      cmp_exp = {m_ce, cmp_lk, cmp_lk, m_err};
      cmp_act = {ce_out, locked, cfg_ready, cfg_err};
      checks++;
      if (cmp_act !== cmp_exp) begin
        errors++;
        $display("FAIL cycle_outputs t=%0t {ce,locked,ready,err} got %b expected %b",
                 $time, cmp_act, cmp_exp);
      end
    end
  end

  // Called at the negedge where rst has just been released.
  task automatic relock(input string tag);
    int e_lock = 0;
    int c0 = 0;
    int c1 = 0;
    for (int e = 1; e <= 24; e++) begin
      @(negedge refclk);
      if (e <= LC && ce_out[0] === 1'b1) c0++;
      if (e <= LC && ce_out[1] === 1'b1) c1++;
      if (e == 3) check({tag, "_ch0_edge3"}, 64'(ce_out[0]), 64'd0);
      if (e == 4) check({tag, "_ch0_edge4"}, 64'(ce_out[0]), 64'd1);
      if (locked === 1'b1 && e_lock == 0) e_lock = e;
    end
    check({tag, "_lock_edge"}, 64'(e_lock), 64'(LC));
    check({tag, "_ch0_cnt"}, 64'(c0), 64'd4);
    check({tag, "_ch1_cnt"}, 64'(c1), 64'(LC));
  endtask

  task automatic send(input logic ch, input logic [AW-1:0] n, input logic [AW-1:0] d);
    cfg_valid = 1'b1;
    cfg_chan  = ch;
    cfg_num   = n;
    cfg_den   = d;
    @(negedge refclk);
    cfg_valid = 1'b0;
  endtask

  task automatic err_window(input string tag);
    int errc = 0;
    int lowc = 0;
    for (int j = 0; j < 5; j++) begin
      if (j > 0) @(negedge refclk);
      if (cfg_err === 1'b1) errc++;
      if (locked !== 1'b1) lowc++;
    end
    check({tag, "_err_pulses"}, 64'(errc), 64'd1);
    check({tag, "_unlocked_cycles"}, 64'(lowc), 64'd0);
  endtask

  initial begin
    int cnt;
    int last;
    int maxgap;
    int lowc;
    int first;
    int c1;

    rst = 1'b1;
    repeat (3) @(negedge refclk);
    check("reset_outputs", 64'({ce_out, locked, cfg_ready, cfg_err}), 64'd0);
    rst = 1'b0;
    relock("init");

    send(1'b0, 24'd0, 24'd7);
    cnt = 0;
    repeat (1000) begin
      @(negedge refclk);
      if (ce_out[0] === 1'b1) cnt++;
    end
    check("num0_strobes", 64'(cnt), 64'd0);

    send(1'b0, 24'd3, 24'd8);
    @(negedge refclk);
    cnt = 0;
    last = 0;
    maxgap = 0;
    for (int k = 1; k <= 800; k++) begin
      @(negedge refclk);
      if (ce_out[0] === 1'b1) begin
        cnt++;
        if (last > 0 && k - last > maxgap) maxgap = k - last;
        last = k;
      end
    end
    check("r3_8_strobes", 64'(cnt), 64'd300);
    check("r3_8_maxgap", 64'(maxgap), 64'd3);

    send(1'b0, 24'd2, 24'd3);
    lowc = 0;
    first = -1;
    c1 = 0;
    for (int j = 0; j < 40; j++) begin
      if (j > 0) @(negedge refclk);
      if (cfg_ready !== 1'b1) lowc++;
      if (ce_out[0] === 1'b1 && first < 0) first = j;
      if (ce_out[1] === 1'b1) c1++;
    end
    check("apply_ready_low", 64'(lowc), 64'd17);
    check("apply_first_strobe", 64'(first), 64'd3);
    check("apply_ch1_steady", 64'(c1), 64'd40);

    send(1'b0, 24'd9, 24'd4);
    err_window("num_gt_den");
    send(1'b1, 24'd3, 24'd0);
    err_window("den_zero");
    cnt = 0;
    repeat (30) begin
      @(negedge refclk);
      if (ce_out[0] === 1'b1) cnt++;
    end
    check("ratio_kept_ch0", 64'(cnt), 64'd20);

    cfg_valid = 1'b1;
    cfg_chan  = 1'b0;
    cfg_num   = 24'd1;
    cfg_den   = 24'd2;
    rst       = 1'b1;
    @(negedge refclk);
    check("rst_handshake_outputs", 64'({ce_out, locked, cfg_ready, cfg_err}), 64'd0);
    cfg_valid = 1'b0;
    rst = 1'b0;
    relock("rst_hs");

    send(1'b1, 24'd1, 24'd3);
    repeat (6) @(negedge refclk);
    rst = 1'b1;
    @(negedge refclk);
    check("rst_settle_outputs", 64'({ce_out, locked, cfg_ready, cfg_err}), 64'd0);
    rst = 1'b0;
    relock("rst_mid");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/frac_clken_gen.md
# frac_clken_gen

Parametrised fractional clock-enable generator. From one master clock it produces CHANNELS independent single-cycle enable strobes, each at the average rate f_refclk × NUM/DEN, using a phase accumulator per channel. Each channel's ratio can be changed at runtime. The block sits directly after the top-level PLL, so the core derives CPU, video and audio rates as enables on one clock instead of adding PLL outputs.

## Interface
Parameters:
- CHANNELS, 2: number of enable channels (1–8).
- ACC_W, 24: accumulator and ratio width in bits.
- LOCK_CYCLES, 16: stable cycles required before `locked` asserts (≥1).
- INIT_NUM, {CHANNELS{24'd1}}: packed per-channel numerators applied at reset; channel i uses bits [i*ACC_W +: ACC_W].
- INIT_DEN, {CHANNELS{24'd4}}: packed per-channel denominators applied at reset.

Ports:
- refclk  in  1  single clock for all logic.
- rst  in  1  synchronous, active-high reset.
- cfg_valid  in  1  reconfiguration request.
- cfg_ready  out  1  block can accept a request this cycle.
- cfg_chan  in  max(1,$clog2(CHANNELS))  target channel.
- cfg_num  in  ACC_W  new numerator.
- cfg_den  in  ACC_W  new denominator.
- cfg_err  out  1  one-cycle pulse when a request is rejected.
- ce_out  out  CHANNELS  per-channel enable strobes, registered.
- locked  out  1  all channels running on their current ratio for LOCK_CYCLES cycles.

## Operation
Reset (rst=1 at an edge):
- acc[i]=0; num/den loaded from INIT_*.
- ce_out=0, locked=0, cfg_ready=0, cfg_err=0, state=SETTLE, lock counter=0.

Per channel, each edge when not in reset:
- sum = acc + num, computed at ACC_W+1 bits.
- If sum ≥ den: acc ← sum − den, ce_out[i] ← 1.
- Otherwise: acc ← sum, ce_out[i] ← 0.
- NUM=0 gives no strobes. NUM=DEN gives a strobe every cycle.

Lock state machine (global):
- SETTLE: counter increments each cycle; cfg_ready=0. When counter = LOCK_CYCLES−1, go to LOCKED.
- LOCKED: locked=1, cfg_ready=1.
- APPLY: entered from LOCKED on a cfg_valid & cfg_ready handshake with a valid request. Lasts exactly one cycle: writes num/den of cfg_chan, clears that channel's acc, forces its ce_out to 0, sets locked=0. Then goes to SETTLE with counter=0.

Request validity:
- Valid requires cfg_den≠0, cfg_num≤cfg_den, and cfg_chan<CHANNELS.
- An invalid request still completes the handshake. cfg_err pulses high the next cycle. No state changes and locked stays 1.

Boundary rules:
- Unaffected channels keep accumulating through APPLY and SETTLE without a phase glitch.
- rst overrides everything, including a handshake in the same cycle.
- cfg_valid while cfg_ready=0 is ignored; the request is not queued.
- INIT values that are invalid are clamped at reset: den=0 becomes 1, and num>den becomes num=den.

## Timing
- Number edges k=1,2,… after the first edge with rst=0, or after APPLY for the reconfigured channel.
- ce_out[i] is high after edge k iff floor(k·NUM/DEN) > floor((k−1)·NUM/DEN).
- Latency from handshake edge: APPLY occupies the next cycle. The new ratio's first accumulation happens at the edge after APPLY.
- locked rises LOCK_CYCLES edges after SETTLE is entered.
- Long-term strobe count over M cycles is within ±1 of M·NUM/DEN.

## Structure
- Shared package `frac_clken_pkg`: the state enum (SETTLE, LOCKED, APPLY), the validity-check function, and the default ACC_W.
- One sub-module, `frac_clken_chan`: a single accumulator with load/clear inputs and a registered ce output, instantiated CHANNELS times by a generate loop.
- The top level holds the lock FSM and the config decode.

## Test plan
- Reset release, NUM=1, DEN=4 → ce_out[0] high after edges 4, 8, 12…; locked rises after edge 16.
- NUM=DEN=5 on ch1 → ce_out[1] high every cycle. NUM=0 → never high over 1000 cycles.
- NUM=3, DEN=8 over 800 cycles → exactly 300 strobes, with no two adjacent strobes spaced more than 3 cycles apart.
- Locked; write ch0 NUM=2, DEN=3 → cfg_ready low for 1+16 cycles; ch0 first strobe at edge 2 after APPLY; ch1 pattern unchanged.
- Request with cfg_num=9, cfg_den=4, then one with cfg_den=0 → cfg_err pulses once for each; locked stays 1; ratios unchanged.
- rst asserted in the same cycle as a handshake, and again mid-SETTLE → all outputs 0 next cycle; INIT ratios restored; relock after 16 cycles.
